link_pair_power_sequencer: RTL and testbench

Sequences power-up of the split-radio front end and the two TIA-568B pair channels (1236, 5478) of the link-power path without PLC. Enables each rail group in turn and waits for it to settle. Qualifies each pair with its PostLNA pair-good indication, then monitors the running link. Only one rail group turns on per step to bound inrush; failed attempts back off and retry, then lock out.

---
 rtl/link_pair_power_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_link_pair_power_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/link_pair_power_sequencer.sv
// link_pair_power_sequencer
// Powers up the split-radio front end, then pair 1236, then pair 5478, one rail
// group per step. Each pair is qualified by a run of consecutive pair-good
// cycles before the next group is enabled. Once the link is up, any pair-good
// loss is a fault. Faults turn all rails off, back off, and retry until the
// retry budget is spent, after which the block locks out until Enable drops.
//
// Optional build macro: PAIR_OK_SYNC_EN -- route both pair-good inputs through
// 2-flop synchronizers (adds 2 cycles to every Ok-related latency).
//
// Ports:
//   Clock100Mhz   in   single clock, rising edge
//   Reset         in   synchronous, active-high
//   Enable        in   level request; low forces shutdown to IDLE
//   Pair1236Ok    in   pair-good for 1236
//   Pair5478Ok    in   pair-good for 5478
//   SplitRadioEn  out  split-radio V+/V- enable
//   RailEn1236    out  op-amp rail enable, pair 1236
//   RailEn5478    out  op-amp rail enable, pair 5478
//   LinkUp        out  high only in RUN
//   Fault         out  high in LOCKOUT
//   FaultPair     out  bit0 = 1236, bit1 = 5478 blamed for last fault
//   StateCode     out  current state encoding
module link_pair_power_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned CHECK_CYCLES   = 256,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned BACKOFF_CYCLES = 100000,
  parameter int unsigned RETRY_LIMIT    = 3
) (
  input  logic       Clock100Mhz,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Pair1236Ok,
  input  logic       Pair5478Ok,
  output logic       SplitRadioEn,
  output logic       RailEn1236,
  output logic       RailEn5478,
  output logic       LinkUp,
  output logic       Fault,
  output logic [1:0] FaultPair,
  output logic [3:0] StateCode
);

  localparam int unsigned DwellMaxSt = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                                       SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned DwellMax   = (DwellMaxSt > BACKOFF_CYCLES) ?
                                       DwellMaxSt : BACKOFF_CYCLES;
  localparam int unsigned DwellW     = $clog2(DwellMax + 1);
  localparam int unsigned CheckW     = $clog2(CHECK_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StRadioOn = 4'd1,
    StAOn     = 4'd2,
    StACheck  = 4'd3,
    StBOn     = 4'd4,
    StBCheck  = 4'd5,
    StRun     = 4'd6,
    StBackoff = 4'd7,
    StLockout = 4'd8
  } state_e;

  state_e              state_q, state_d;
  logic [DwellW-1:0]   dwell_q;
  logic [CheckW-1:0]   check_q;
  logic [3:0]          retry_q;
  logic                ok_a, ok_b;
  logic                fault;
  logic [1:0]          blame;
  logic                settle_done, timeout_hit, backoff_done, check_done, cur_ok, timed;

`ifdef PAIR_OK_SYNC_EN
  logic [1:0] sync_a_q, sync_b_q;
  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      sync_a_q <= 2'b00;
      sync_b_q <= 2'b00;
    end else begin
      sync_a_q <= {sync_a_q[0], Pair1236Ok};
      sync_b_q <= {sync_b_q[0], Pair5478Ok};
    end
  end
  assign ok_a = sync_a_q[1];
  assign ok_b = sync_b_q[1];
`else
  assign ok_a = Pair1236Ok;
  assign ok_b = Pair5478Ok;
`endif

  // Dwell counter holds the number of completed cycles in the current state
  // minus one at each edge, so a dwell of N exits when it reads N-1.
  assign settle_done  = (dwell_q == DwellW'(SETTLE_CYCLES - 1));
  assign timeout_hit  = (dwell_q == DwellW'(TIMEOUT_CYCLES - 1));
  assign backoff_done = (dwell_q == DwellW'(BACKOFF_CYCLES - 1));
  assign cur_ok       = (state_q == StACheck) ? ok_a : ok_b;
  assign check_done   = cur_ok && (check_q == CheckW'(CHECK_CYCLES - 1));
  assign timed        = (state_q != StIdle) && (state_q != StRun) && (state_q != StLockout);

  always_comb begin
    state_d = state_q;
    fault   = 1'b0;
    blame   = 2'b00;
    unique case (state_q)
      StIdle:    if (Enable) state_d = StRadioOn;
      StRadioOn: if (settle_done) state_d = StAOn;
      StAOn:     if (settle_done) state_d = StACheck;
      StACheck: begin
        if (check_done) begin
          state_d = StBOn;
        end else if (timeout_hit) begin
          fault = 1'b1;
          blame = 2'b01;
        end
      end
      StBOn:     if (settle_done) state_d = StBCheck;
      StBCheck: begin
        // Pair 1236 must stay good while 5478 is being qualified.
        if (!ok_a) begin
          fault = 1'b1;
          blame = 2'b01;
        end else if (check_done) begin
          state_d = StRun;
        end else if (timeout_hit) begin
          fault = 1'b1;
          blame = 2'b10;
        end
      end
      StRun: begin
        if (!ok_a || !ok_b) begin
          fault = 1'b1;
          blame = {~ok_b, ~ok_a};
        end
      end
      StBackoff: if (backoff_done) state_d = StRadioOn;
      StLockout: state_d = StLockout;
      default:   state_d = StIdle;
    endcase
    if (fault) begin
      state_d = (({1'b0, retry_q} + 5'd1) >= 5'(RETRY_LIMIT)) ? StLockout : StBackoff;
    end
    // Shutdown request outranks any fault decision.
    if (!Enable) state_d = StIdle;
  end

  always_ff @(posedge Clock100Mhz) begin
    if (Reset) begin
      state_q      <= StIdle;
      dwell_q      <= '0;
      check_q      <= '0;
      retry_q      <= '0;
      FaultPair    <= 2'b00;
      SplitRadioEn <= 1'b0;
      RailEn1236   <= 1'b0;
      RailEn5478   <= 1'b0;
      LinkUp       <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q || !timed) dwell_q <= '0;
      else                               dwell_q <= dwell_q + 1'b1;

      if (state_d != state_q)                                 check_q <= '0;
      else if ((state_q == StACheck || state_q == StBCheck) && cur_ok)
                                                              check_q <= check_q + 1'b1;
      else                                                    check_q <= '0;

      if (!Enable)                                   retry_q <= '0;
      else if (state_d == StRun && state_q != StRun) retry_q <= '0;
      else if (fault)                                retry_q <= retry_q + 4'd1;

      if (!Enable) begin
        if (state_q == StLockout) FaultPair <= 2'b00;
      end else if (fault) begin
        FaultPair <= blame;
      end

      SplitRadioEn <= (state_d == StRadioOn) || (state_d == StAOn) || (state_d == StACheck) ||
                      (state_d == StBOn) || (state_d == StBCheck) || (state_d == StRun);
      RailEn1236   <= (state_d == StAOn) || (state_d == StACheck) || (state_d == StBOn) ||
                      (state_d == StBCheck) || (state_d == StRun);
      RailEn5478   <= (state_d == StBOn) || (state_d == StBCheck) || (state_d == StRun);
      LinkUp       <= (state_d == StRun);
      Fault        <= (state_d == StLockout);
    end
  end

  assign StateCode = state_q;

endmodule

// File: tb/tb_link_pair_power_sequencer.sv
module tb_link_pair_power_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ok_a;
  logic       ok_b;
  logic       split_en;
  logic       rail_a;
  logic       rail_b;
  logic       link_up;
  logic       fault;
  logic [1:0] fault_pair;
  logic [3:0] state_code;

  int checks   = 0;
  int failures = 0;

  // Expected StateCode after edge c of the nominal sequence (Enable set at cycle 0).
  int unsigned nom_state [20] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 4, 4, 4, 4, 5, 5, 5, 6};

  link_pair_power_sequencer #(
    .SETTLE_CYCLES (4),
    .CHECK_CYCLES  (3),
    .TIMEOUT_CYCLES(10),
    .BACKOFF_CYCLES(8),
    .RETRY_LIMIT   (2)
  ) dut (
    .Clock100Mhz (clk),
    .Reset       (rst),
    .Enable      (en),
    .Pair1236Ok  (ok_a),
    .Pair5478Ok  (ok_b),
    .SplitRadioEn(split_en),
    .RailEn1236  (rail_a),
    .RailEn5478  (rail_b),
    .LinkUp      (link_up),
    .Fault       (fault),
    .FaultPair   (fault_pair),
    .StateCode   (state_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {SplitRadioEn, RailEn1236, RailEn5478, LinkUp, Fault}
  function automatic logic [31:0] outs();
    return {27'd0, split_en, rail_a, rail_b, link_up, fault};
  endfunction

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    ok_a = 1'b0;
    ok_b = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("reset_state", state_code, 0);
    chk("reset_outs", outs(), 5'b00000);
    chk("reset_fp", fault_pair, 2'b00);

    // Nominal power-up.
    en = 1'b1; ok_a = 1'b1; ok_b = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      tick(1);
      chk($sformatf("nom_state_c%0d", c), state_code, nom_state[c]);
      if (c == 1)  chk("nom_radio_on_c1", outs(), 5'b10000);
      if (c == 4)  chk("nom_radio_only_c4", outs(), 5'b10000);
      if (c == 5)  chk("nom_rail_a_c5", outs(), 5'b11000);
      if (c == 12) chk("nom_rail_b_c12", outs(), 5'b11100);
      if (c == 18) chk("nom_not_up_c18", outs(), 5'b11100);
    end
    chk("nom_linkup_c19", outs(), 5'b11110);

    // Loss of both pairs in RUN.
    ok_a = 1'b0; ok_b = 1'b0;
    tick(1);
    chk("runloss_state", state_code, 7);
    chk("runloss_outs", outs(), 5'b00000);
    chk("runloss_fp", fault_pair, 2'b11);
    ok_a = 1'b1; ok_b = 1'b1; en = 1'b0;
    tick(1);
    chk("runloss_idle", state_code, 0);
    chk("runloss_fp_held", fault_pair, 2'b11);

    // 1236 stuck low: timeout, backoff, timeout, lockout.
    en = 1'b1; ok_a = 1'b0; ok_b = 1'b1;
    tick(18);
    chk("to_acheck_c18", state_code, 3);
    tick(1);
    chk("to_backoff_c19", state_code, 7);
    chk("to_backoff_outs", outs(), 5'b00000);
    chk("to_fp01", fault_pair, 2'b01);
    tick(7);
    chk("to_backoff_c26", state_code, 7);
    tick(1);
    chk("to_retry_c27", state_code, 1);
    tick(17);
    chk("to_acheck_c44", state_code, 3);
    tick(1);
    chk("to_lockout_c45", state_code, 8);
    chk("to_lockout_outs", outs(), 5'b00001);
    chk("to_lockout_fp", fault_pair, 2'b01);
    tick(3);
    chk("to_lockout_hold", state_code, 8);
    en = 1'b0;
    tick(1);
    chk("to_exit_state", state_code, 0);
    chk("to_exit_outs", outs(), 5'b00000);
    chk("to_exit_fp", fault_pair, 2'b00);

    // 5478 stuck low: one fault, then Enable drop in B_ON clears the retry count.
    en = 1'b1; ok_a = 1'b1; ok_b = 1'b0;
    tick(25);
    chk("ed_bcheck_c25", state_code, 5);
    tick(1);
    chk("ed_backoff_c26", state_code, 7);
    chk("ed_fp10", fault_pair, 2'b10);
    tick(19);
    chk("ed_bon_c45", state_code, 4);
    chk("ed_bon_outs", outs(), 5'b11100);
    en = 1'b0;
    tick(1);
    chk("ed_idle_state", state_code, 0);
    chk("ed_idle_outs", outs(), 5'b00000);
    chk("ed_fp_held", fault_pair, 2'b10);
    en = 1'b1; ok_a = 1'b0; ok_b = 1'b1;
    tick(1);
    chk("ed_restart_c1", state_code, 1);
    tick(18);
    chk("ed_backoff_not_lock", state_code, 7);
    chk("ed_fp01", fault_pair, 2'b01);
    en = 1'b0;
    tick(1);
    chk("ed_idle2", state_code, 0);

    // One-cycle 5478 glitch in B_CHECK restarts qualification.
    en = 1'b1; ok_a = 1'b1; ok_b = 1'b1;
    tick(18);
    chk("gl_bcheck_c18", state_code, 5);
    ok_b = 1'b0;
    tick(1);
    chk("gl_glitch_c19", state_code, 5);
    ok_b = 1'b1;
    tick(2);
    chk("gl_still_c21", state_code, 5);
    tick(1);
    chk("gl_run_c22", state_code, 6);
    chk("gl_run_outs", outs(), 5'b11110);

    // Reset while running.
    rst = 1'b1;
    tick(1);
    chk("rst_state", state_code, 0);
    chk("rst_outs", outs(), 5'b00000);
    chk("rst_fp", fault_pair, 2'b00);
    rst = 1'b0;
    tick(1);
    chk("rst_restart", state_code, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
